// File: rtl/fetch_sequencer_if.sv
// Instruction-fetch bus bundle: memory-side req/gnt/rvalid port plus the
// decode-side instruction buffer port. master = fetch sequencer, slave = environment.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// RV32I fetch sequencer: owns the PC, issues credit-limited fetches and buffers
// returned words with their PC. Define FETCH_PERF_CNT_EN to add perf counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
`endif
  fetch_sequencer_if.master bus
);
  localparam int               PTR_W       = $clog2(FIFO_DEPTH);
  localparam int               CNT_W       = $clog2(FIFO_DEPTH + MAX_OUTST + 1);
  localparam logic [CNT_W:0]   DEPTH_C     = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] MAX_OUTST_C = CNT_W'(MAX_OUTST);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              misalign_q, misalign_d;
  logic [31:0]       fifo_instr_q [FIFO_DEPTH];
  logic [31:0]       fifo_pc_q    [FIFO_DEPTH];

  logic        credit_ok;
  logic        req;
  logic        issue;
  logic        push;
  logic        pop;
  logic        instr_valid;
  logic [31:0] redirect_aligned;

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign instr_valid      = (count_q != '0);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_BOOT;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = fetch_en ? ST_RUN : ST_IDLE;
      ST_IDLE: if (fetch_en)  state_d = ST_RUN;
      ST_RUN:  if (!fetch_en) state_d = ST_IDLE;
      default: state_d = ST_BOOT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Counting in-flight requests against free buffer slots means every
  // response that arrives is guaranteed a place to land.
  always_comb begin
    credit_ok = (({1'b0, outst_q} + {1'b0, count_q}) < DEPTH_C) &&
                (outst_q < MAX_OUTST_C);
    req = 1'b0;
    if ((state_q == ST_RUN) && !redirect_valid && credit_ok) req = 1'b1;
  end

  // ---------------- datapath next-state ----------------
  always_comb begin
    issue      = req && bus.imem_gnt;
    pop        = instr_valid && bus.instr_ready;
    push       = bus.imem_rvalid && !redirect_valid && (discard_q == '0);
    outst_d    = outst_q + CNT_W'(issue) - CNT_W'(bus.imem_rvalid);
    misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (redirect_valid) begin
      // Everything still owed by memory after this edge is stale.
      pc_d      = redirect_aligned;
      resp_pc_d = redirect_aligned;
      discard_d = outst_d;
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end else begin
      if (issue) pc_d = pc_q + 32'd4;
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      end else if (bus.imem_rvalid) begin
        discard_d = discard_q - CNT_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ---------------- control registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      misalign_q <= misalign_d;
    end
  end

  // Buffer storage needs no reset: the head is masked while the count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= bus.imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

  // ---------------- outputs ----------------
  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = instr_valid;
  assign bus.instr       = instr_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
  assign bus.instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0;
  assign misalign_err    = misalign_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + (pop ? 32'd1 : 32'd0);
    perf_stall_d   = perf_stall_q +
                     (((state_q == ST_RUN) && !instr_valid && !redirect_valid) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

  // A response with nothing in flight means the memory side lost sync with us.
  a_no_orphan_rvalid: assert property (
    @(posedge clk) disable iff (reset) bus.imem_rvalid |-> (outst_q != '0)
  );

endmodule
